// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch/realign stage.
package fetch_pkg;

  localparam int          PARCEL_W    = 16;
  localparam int          QUEUE_DEPTH = 4;
  localparam logic [31:0] BUBBLE_INS  = 32'h0;

  typedef logic [PARCEL_W-1:0] parcel_t;

  // Any low-bit pattern other than 2'b11 marks a 16-bit RVC parcel.
  function automatic logic is_rvc(input parcel_t parcel);
    return parcel[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_align_parcel_queue.sv
// 4-deep 16-bit parcel shift queue; pushed parcels are visible at the head in the same cycle.
// Pops are taken from the merged view (stored + incoming), so push and pop may coincide.
module parcel_queue
  import fetch_pkg::*;
(
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_clear,
  input  logic [1:0]    i_push_n,
  input  parcel_t [1:0] i_push_dat,
  input  logic [1:0]    i_pop_n,
  output parcel_t [1:0] o_head,
  output logic [2:0]    o_avail,
  output logic [2:0]    o_count
);

  parcel_t [QUEUE_DEPTH-1:0] r_q;
  parcel_t [QUEUE_DEPTH-1:0] w_view;
  parcel_t [QUEUE_DEPTH-1:0] w_next;
  logic [2:0]                r_count;
  logic [2:0]                w_avail;

  // Incoming parcels land directly behind the stored ones.
  always_comb begin
    w_view = r_q;
    if (i_push_n != 2'd0 && r_count < 3'd4) begin
      w_view[r_count[1:0]] = i_push_dat[0];
    end
    if (i_push_n == 2'd2 && r_count < 3'd3) begin
      w_view[r_count[1:0] + 2'd1] = i_push_dat[1];
    end
  end

  always_comb begin
    case (i_pop_n)
      2'd1:    w_next = {{PARCEL_W{1'b0}}, w_view[3:1]};
      2'd2:    w_next = {{2*PARCEL_W{1'b0}}, w_view[3:2]};
      default: w_next = w_view;
    endcase
  end

  assign w_avail = r_count + {1'b0, i_push_n};
  assign o_avail = w_avail;
  assign o_count = r_count;
  assign o_head  = w_view[1:0];

  always_ff @(posedge clk) begin
    if (i_rst || i_clear) begin
      r_q     <= '0;
      r_count <= 3'd0;
    end else begin
      r_q     <= w_next;
      r_count <= w_avail - {1'b0, i_pop_n};
    end
  end

endmodule

// File: rtl/fetch_align.sv
// IF stage: word fetch, RV32I/RVC realignment into IF/ID; 2 cycles redirect-to-valid.
// Stall freezes IF/ID while fetch fills the parcel queue; requests stop when it would overflow.
module fetch_align
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              Rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [31:0]       ins,
  output logic [ADDR_W-1:0] IF_ID_pres_addr,
  output logic              comp_sig,
  output logic              ins_valid
);

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_head_pc;
  logic              r_inflight;
  logic              r_skip_lo;
  logic [31:0]       r_ins;
  logic [ADDR_W-1:0] r_pres_addr;
  logic              r_comp;
  logic              r_valid;

  logic              w_resp;
  logic [1:0]        w_push_n;
  parcel_t [1:0]     w_push_dat;
  parcel_t [1:0]     w_head;
  logic [2:0]        w_avail;
  logic [2:0]        w_count;
  logic              w_rvc;
  logic [1:0]        w_need;
  logic              w_take;
  logic [1:0]        w_pop_n;
  logic [3:0]        w_budget;
  logic              w_req;

  // A redirect suppresses the request in its own cycle, so the only stale
  // response is the one arriving alongside the redirect, dropped by the clear.
  assign w_resp   = r_inflight;
  assign w_push_n = !w_resp ? 2'd0 : (r_skip_lo ? 2'd1 : 2'd2);

  always_comb begin
    w_push_dat    = '0;
    w_push_dat[0] = r_skip_lo ? imem_rdata[31:16] : imem_rdata[15:0];
    w_push_dat[1] = imem_rdata[31:16];
  end

  parcel_queue u_queue (
    .clk        (clk),
    .i_rst      (Rst),
    .i_clear    (redirect),
    .i_push_n   (w_push_n),
    .i_push_dat (w_push_dat),
    .i_pop_n    (w_pop_n),
    .o_head     (w_head),
    .o_avail    (w_avail),
    .o_count    (w_count)
  );

  assign w_rvc   = is_rvc(w_head[0]);
  assign w_need  = w_rvc ? 2'd1 : 2'd2;
  assign w_take  = !redirect && !stall && (w_avail >= {1'b0, w_need});
  assign w_pop_n = w_take ? w_need : 2'd0;

  // Reserve two slots for the new word plus two for any word still in flight.
  assign w_budget = {1'b0, w_count} + (r_inflight ? 4'd2 : 4'd0) + 4'd2 - {2'b00, w_pop_n};
  assign w_req    = !Rst && !redirect && (w_budget <= 4'd4);

  assign imem_req        = w_req;
  assign imem_addr       = r_fetch_pc;
  assign ins             = r_ins;
  assign IF_ID_pres_addr = r_pres_addr;
  assign comp_sig        = r_comp;
  assign ins_valid       = r_valid;

  always_ff @(posedge clk) begin
    if (Rst) begin
      r_fetch_pc  <= {RESET_PC[ADDR_W-1:2], 2'b00};
      r_head_pc   <= RESET_PC;
      r_inflight  <= 1'b0;
      r_skip_lo   <= RESET_PC[1];
      r_ins       <= BUBBLE_INS;
      r_pres_addr <= '0;
      r_comp      <= 1'b0;
      r_valid     <= 1'b0;
    end else if (redirect) begin
      r_fetch_pc  <= {redirect_addr[ADDR_W-1:2], 2'b00};
      r_head_pc   <= redirect_addr;
      r_inflight  <= 1'b0;
      r_skip_lo   <= redirect_addr[1];
      r_ins       <= BUBBLE_INS;
      r_pres_addr <= redirect_addr;
      r_comp      <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
      end
      if (w_resp) begin
        r_skip_lo <= 1'b0;
      end
      if (!stall) begin
        r_pres_addr <= r_head_pc;
        if (w_take) begin
          r_ins     <= w_rvc ? {16'h0, w_head[0]} : {w_head[1], w_head[0]};
          r_comp    <= w_rvc;
          r_valid   <= 1'b1;
          r_head_pc <= r_head_pc + (w_rvc ? ADDR_W'(2) : ADDR_W'(4));
        end else begin
          r_ins   <= BUBBLE_INS;
          r_comp  <= 1'b0;
          r_valid <= 1'b0;
        end
      end
    end
  end

endmodule
